calc_op_sequencer: RTL and testbench

- Sits between the user controls (enter, select, a, b) and the ALU on the calculator top level.
- Conditions the raw enter button with a synchronizer and debouncer, and turns each press into exactly one ALU operation.
- Latches the operands and opcode for that operation and runs the ALU through a start/done handshake with a timeout.
- Holds the last result stable for the BCD, seven-segment and VGA paths.

---
 rtl/calc_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_calc_op_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// Purpose: turns each debounced enter press into exactly one ALU operation
//   (latch operands, start pulse, wait for done or timeout) and holds the result.
// Latency: alu_start rises DEBOUNCE_CYCLES+2 edges after enter is first sampled
//   high; a result is captured on the edge after alu_done.
// Backpressure: none; a press arriving while busy is dropped and flagged on overrun.
// Ports:
//   clk, ar            clock, synchronous active-high reset
//   enter              raw async button; a/b/select operands and opcode
//   alu_a/b/sel/start  latched request to the ALU; alu_done/alu_f its answer
//   res_f/res_valid    held result; timeout = last op aborted
//   busy, overrun      op in flight; one-cycle dropped-press pulse
//   op_count           completed operations, wraps at 256
module calc_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic       clk,
  input  logic       ar,
  input  logic       enter,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] select,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic [7:0] alu_f,
  output logic [7:0] res_f,
  output logic       res_valid,
  output logic       busy,
  output logic       timeout,
  output logic       overrun,
  output logic [7:0] op_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic            sync_1;
  logic            sync_2;
  logic            deb;
  logic            deb_q;
  logic [DB_W-1:0] deb_cnt;
  logic [TO_W-1:0] wait_cnt;
  logic            press;

  // Enter conditioning: two-flop synchronizer, then the debounced level only
  // follows the synchronized level after it has disagreed for DEBOUNCE_CYCLES
  // consecutive cycles.
  always_ff @(posedge clk) begin
    if (ar) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_1 <= enter;
      sync_2 <= sync_1;
      deb_q  <= deb;
      if (sync_2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_LAST) begin
        deb     <= sync_2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Only rising edges of the debounced level count as presses.
  assign press   = deb & ~deb_q;
  // Flags the press in the very cycle it is dropped.
  assign overrun = press & busy;

  always_ff @(posedge clk) begin
    if (ar) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      alu_start <= 1'b0;
      res_f     <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      op_count  <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press) begin
            alu_a     <= a;
            alu_b     <= b;
            alu_sel   <= select;
            res_valid <= 1'b0;
            timeout   <= 1'b0;
            wait_cnt  <= '0;
            alu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_start <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the last allowed cycle still wins over the abort.
          if (alu_done) begin
            res_f     <= alu_f;
            res_valid <= 1'b1;
            op_count  <= op_count + 8'd1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (wait_cnt == TO_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          alu_start <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer with short debounce/timeout parameters.
// Each operation is described by when enter is held and when alu_done arrives;
// the expected output timeline is derived from those event times.
module tb_calc_op_sequencer;

  localparam int DB = 4;
  localparam int TO = 8;
  localparam int S  = DB + 2;   // edge after which alu_start is high

  logic       clk = 1'b0;
  logic       ar;
  logic       enter;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] select;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic       alu_start;
  logic       alu_done;
  logic [7:0] alu_f;
  logic [7:0] res_f;
  logic       res_valid;
  logic       busy;
  logic       timeout;
  logic       overrun;
  logic [7:0] op_count;

  calc_op_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .ar       (ar),
    .enter    (enter),
    .a        (a),
    .b        (b),
    .select   (select),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_start(alu_start),
    .alu_done (alu_done),
    .alu_f    (alu_f),
    .res_f    (res_f),
    .res_valid(res_valid),
    .busy     (busy),
    .timeout  (timeout),
    .overrun  (overrun),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: what the held-result outputs should show.
  logic [7:0] exp_res   = 8'd0;
  logic       exp_valid = 1'b0;
  logic       exp_to    = 1'b0;
  int         exp_cnt   = 0;
  int         completed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_held();
    check("res_f", res_f, exp_res);
    check("res_valid", res_valid, exp_valid);
    check("timeout", timeout, exp_to);
    check("op_count", op_count, exp_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_sel"}, alu_sel, 0);
    check({tag, "_alu_start"}, alu_start, 0);
    check({tag, "_res_f"}, res_f, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_op_count"}, op_count, 0);
  endtask

  // One operation. Index e counts the edges from the first one sampling enter=1.
  // j: alu_done is high in the cycle after edge S+j (0 = while still issuing).
  // repress: enter released after DB samples and pressed again at edge 2*DB.
  task automatic run_op(input logic [3:0] oa, input logic [3:0] ob, input logic [1:0] os,
                        input int hold, input int j, input bit repress, input logic [7:0] f);
    bit ok;
    int eend;
    int pe;
    int last;
    ok   = (j >= 1) && (j <= TO);
    eend = ok ? (S + j + 1) : (S + TO + 1);
    pe   = repress ? (3 * DB + 1) : -1;
    last = eend + 2 * DB + 4;
    for (int e = 0; e <= last; e++) begin
      enter    = (e < hold) || (repress && (e >= 2 * DB) && (e < 3 * DB));
      alu_done = (e == S + j + 1);
      alu_f    = (e == S + j + 1) ? f : 8'($urandom);
      if (e <= S) begin
        a = oa; b = ob; select = os;
      end else begin
        a = 4'($urandom); b = 4'($urandom); select = 2'($urandom);
      end
      @(posedge clk); #1;
      if (e == S) begin
        exp_valid = 1'b0;
        exp_to    = 1'b0;
      end
      if (e == eend) begin
        if (ok) begin
          exp_res   = f;
          exp_valid = 1'b1;
          exp_cnt   = (exp_cnt + 1) % 256;
          completed++;
        end else begin
          exp_to = 1'b1;
        end
      end
      check("alu_start", alu_start, e == S);
      check("busy", busy, (e >= S) && (e < eend));
      check("overrun", overrun, e == pe);
      check_held();
      if (e >= S) begin
        check("alu_a", alu_a, oa);
        check("alu_b", alu_b, ob);
        check("alu_sel", alu_sel, os);
      end
    end
  endtask

  // Enter high for fewer than DB samples must never start anything.
  task automatic glitch(input int len);
    for (int e = 0; e <= len + DB + 6; e++) begin
      enter    = (e < len);
      alu_done = 1'b0;
      @(posedge clk); #1;
      check("glitch_start", alu_start, 0);
      check("glitch_busy", busy, 0);
      check("glitch_overrun", overrun, 0);
      check_held();
    end
  endtask

  // Reset while waiting on the ALU; the late alu_done must be ignored.
  task automatic reset_mid();
    for (int e = 0; e <= S + 8; e++) begin
      enter    = (e < DB);
      ar       = (e == S + 3);
      alu_done = (e == S + 4);
      alu_f    = 8'hFF;
      a = 4'h5; b = 4'h9; select = 2'd3;
      @(posedge clk); #1;
      if (e == S) begin
        exp_valid = 1'b0;
        exp_to    = 1'b0;
      end
      if (e == S + 3) begin
        exp_res = 8'd0; exp_valid = 1'b0; exp_to = 1'b0; exp_cnt = 0;
        check_all_zero("mid_reset");
      end else begin
        check("rst_busy", busy, (e >= S) && (e < S + 3));
        check_held();
      end
    end
    ar = 1'b0;
  endtask

  initial begin
    int ops;
    int r;
    int j;
    ar = 1'b1; enter = 1'b0; a = '0; b = '0; select = '0;
    alu_done = 1'b0; alu_f = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    ar = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Directed cases.
    run_op(4'b0011, 4'b1110, 2'b01, DB + 4, 2, 1'b0, 8'h2A);
    glitch(3);
    run_op(4'h7, 4'h2, 2'd2, DB, 8, 1'b1, 8'h5C);   // overrun, done on last allowed cycle
    run_op(4'h1, 4'hF, 2'd0, DB, 20, 1'b1, 8'h11);  // overrun and timeout
    run_op(4'hA, 4'h4, 2'd3, DB + 1, 0, 1'b0, 8'h77); // done during issue: ignored, timeout
    run_op(4'h6, 4'h6, 2'd1, DB, 1, 1'b0, 8'hC3);   // next press clears timeout
    reset_mid();
    repeat (3) @(posedge clk);
    #1;

    // Random operations until op_count has wrapped.
    ops = 0;
    while ((completed < 260) && (ops < 700)) begin
      ops++;
      r = $urandom_range(0, 7);
      if (r == 0) begin
        glitch($urandom_range(1, DB - 1));
      end else if (r == 1) begin
        j = $urandom_range(7, 12);
        run_op(4'($urandom), 4'($urandom), 2'($urandom), DB, j, 1'b1, 8'($urandom));
      end else begin
        j = (r == 2) ? $urandom_range(0, 12) : $urandom_range(1, TO);
        run_op(4'($urandom), 4'($urandom), 2'($urandom), $urandom_range(DB, DB + 4),
               j, 1'b0, 8'($urandom));
      end
    end
    check("wrapped", completed >= 256, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
